// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch (I) and load/store (D) onto one single-port RAM; define MEM_ARB_RR_EN for round-robin priority.
// Latency: gnt 1 cycle after req is seen in IDLE, rvalid/rdata 1 cycle after gnt; out-of-range gets gnt+err at +1.
// Backpressure: requesters hold req until gnt; one access in flight, reads 1 per 3 cycles, writes 1 per 2.
module mem_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 256
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              i_err,
    output logic              mem_rden,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_readout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_WORDS);

    state_t            state_q;
    logic              port_d_q;
    logic              we_q;
    logic              i_gnt_q, d_gnt_q;
    logic              i_rvalid_q, d_rvalid_q;
    logic              i_err_q, d_err_q;
    logic              mem_rden_q, mem_wren_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;
    logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

    logic              any_req;
    logic              pick_d;
    logic              oor;
    logic [ADDR_W-1:0] win_addr;

`ifdef MEM_ARB_RR_EN
    logic prio_d_q;

    assign pick_d = d_req && (prio_d_q || !i_req);

    // Pointer moves to the loser on every grant, error grants included.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            prio_d_q <= 1'b1;
        end else if (state_q == S_IDLE && any_req) begin
            prio_d_q <= !pick_d;
        end
    end
`else
    assign pick_d = d_req;
`endif

    assign any_req  = i_req | d_req;
    assign win_addr = pick_d ? d_addr : i_addr;
    assign oor      = {1'b0, win_addr} >= MEM_LIMIT;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            port_d_q   <= 1'b0;
            we_q       <= 1'b0;
            i_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_err_q    <= 1'b0;
            d_err_q    <= 1'b0;
            mem_rden_q <= 1'b0;
            mem_wren_q <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            i_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_err_q    <= 1'b0;
            d_err_q    <= 1'b0;
            mem_rden_q <= 1'b0;
            mem_wren_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        port_d_q <= pick_d;
                        we_q     <= pick_d & d_we;
                        d_gnt_q  <= pick_d;
                        i_gnt_q  <= !pick_d;
                        if (oor) begin
                            // Rejected without a memory cycle; the port's rdata reads back 0.
                            state_q <= S_ERR;
                            d_err_q <= pick_d;
                            i_err_q <= !pick_d;
                            if (pick_d) d_rdata_q <= '0;
                            else        i_rdata_q <= '0;
                        end else begin
                            state_q    <= S_ISSUE;
                            mem_addr_q <= win_addr;
                            mem_data_q <= pick_d ? d_wdata : '0;
                            mem_wren_q <= pick_d & d_we;
                            mem_rden_q <= !(pick_d & d_we);
                        end
                    end
                end
                S_ISSUE: begin
                    if (we_q) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q    <= S_RESP;
                        d_rvalid_q <= port_d_q;
                        i_rvalid_q <= !port_d_q;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    if (port_d_q) d_rdata_q <= mem_readout;
                    else          i_rdata_q <= mem_readout;
                end
                S_ERR: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // RAM data arrives during RESP; forward it that cycle, then serve it from the hold register.
    assign i_rdata  = i_rvalid_q ? mem_readout : i_rdata_q;
    assign d_rdata  = d_rvalid_q ? mem_readout : d_rdata_q;

    assign i_gnt    = i_gnt_q;
    assign d_gnt    = d_gnt_q;
    assign i_rvalid = i_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign i_err    = i_err_q;
    assign d_err    = d_err_q;
    assign mem_rden = mem_rden_q;
    assign mem_wren = mem_wren_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomised checks of mem_arbiter against a transaction-level memory/response model.
module tb_mem_arbiter;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        i_req, d_req, d_we;
    logic [9:0]  i_addr, d_addr;
    logic [31:0] d_wdata;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, d_err, i_err;
    logic [31:0] i_rdata, d_rdata;
    logic        mem_rden, mem_wren;
    logic [9:0]  mem_addr;
    logic [31:0] mem_data;
    logic [31:0] mem_readout;

    mem_arbiter dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .d_err(d_err), .i_err(i_err),
        .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_readout(mem_readout)
    );

    always #5 Clk = ~Clk;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    function automatic logic [31:0] init_word(input int k);
        return (k == 0) ? 32'h0000_0013 : (32'hC0DE_0000 | 32'(k));
    endfunction

    // Environment RAM: registered read, low address bits decoded.
    logic        mem_clr;
    logic [31:0] mem [256];
    always @(posedge Clk) begin
        if (mem_clr) begin
            for (int k = 0; k < 256; k++) mem[k] <= init_word(k);
        end else begin
            if (mem_wren) mem[mem_addr[7:0]] <= mem_data;
            if (mem_rden) mem_readout <= mem[mem_addr[7:0]];
        end
    end

    logic [31:0] ref_mem [256];
    logic [31:0] exp_d, exp_i;
    int checks = 0;
    int errors = 0;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One isolated access, started in an IDLE cycle; returns in the next IDLE cycle.
    task automatic run_txn(input bit pd, input bit we, input logic [9:0] addr, input logic [31:0] wd);
        bit oor = (addr >= 10'd256);
        bit rd  = !we && !oor;
        if (pd) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd; end
        else begin i_req = 1'b1; i_addr = addr; end
        tick;
        chk("gnt_d", d_gnt, pd);
        chk("gnt_i", i_gnt, !pd);
        chk("err_d", d_err, pd && oor);
        chk("err_i", i_err, !pd && oor);
        chk("rden", mem_rden, rd);
        chk("wren", mem_wren, we && !oor);
        if (!oor) chkw("mem_addr", 32'(mem_addr), 32'(addr));
        if (we && !oor) chkw("mem_data", mem_data, wd);
        if (oor) begin
            if (pd) exp_d = '0;
            else    exp_i = '0;
        end
        chkw("rdata_d_p1", d_rdata, exp_d);
        chkw("rdata_i_p1", i_rdata, exp_i);
        tick;
        d_req = 1'b0;
        i_req = 1'b0;
        if (we && !oor) ref_mem[addr[7:0]] = wd;
        if (rd) begin
            if (pd) exp_d = ref_mem[addr[7:0]];
            else    exp_i = ref_mem[addr[7:0]];
        end
        chk("rvalid_d", d_rvalid, pd && rd);
        chk("rvalid_i", i_rvalid, !pd && rd);
        chk("gnt_p2", d_gnt | i_gnt, 1'b0);
        chk("mem_en_p2", mem_rden | mem_wren, 1'b0);
        chkw("rdata_d_p2", d_rdata, exp_d);
        chkw("rdata_i_p2", i_rdata, exp_i);
        if (rd) begin
            tick;
            chk("rvalid_p3", d_rvalid | i_rvalid, 1'b0);
            chkw("rdata_d_hold", d_rdata, exp_d);
            chkw("rdata_i_hold", i_rdata, exp_i);
        end
    endtask

    initial begin
        bit          glog[$];
        bit          pend, seen, pd, we;
        int          ngr, nrv, rd_cnt;
        logic [9:0]  ra;

        Reset_n = 1'b0; mem_clr = 1'b1;
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
        exp_d = '0; exp_i = '0;
        tick; tick; tick;

        chk("rst_gnt", i_gnt | d_gnt, 1'b0);
        chk("rst_rvalid", i_rvalid | d_rvalid, 1'b0);
        chk("rst_err", i_err | d_err, 1'b0);
        chk("rst_mem_en", mem_rden | mem_wren, 1'b0);
        chkw("rst_mem_addr", 32'(mem_addr), 32'h0);
        chkw("rst_mem_data", mem_data, 32'h0);
        chkw("rst_d_rdata", d_rdata, 32'h0);
        chkw("rst_i_rdata", i_rdata, 32'h0);
        Reset_n = 1'b1; mem_clr = 1'b0;
        tick;

        run_txn(1'b1, 1'b1, 10'd5, 32'hDEAD_BEEF);
        run_txn(1'b1, 1'b0, 10'd5, 32'h0);
        chkw("wr_rd_5", d_rdata, 32'hDEAD_BEEF);

        run_txn(1'b0, 1'b0, 10'd0, 32'h0);
        chkw("fetch_0", i_rdata, 32'h0000_0013);

        run_txn(1'b1, 1'b1, 10'd44, 32'h4444_0044);
        run_txn(1'b1, 1'b1, 10'd300, 32'hBAD0_BAD0);
        run_txn(1'b1, 1'b0, 10'd44, 32'h0);
        chkw("oor_untouched", d_rdata, 32'h4444_0044);
        run_txn(1'b0, 1'b0, 10'd512, 32'h0);

        // Back-to-back reads with d_req held across grants.
        d_we = 1'b0; d_addr = 10'd1; d_req = 1'b1;
        pend = 1'b0; ngr = 0; nrv = 0; rd_cnt = 0;
        for (int c = 1; c <= 10; c++) begin
            tick;
            if (pend) begin
                pend = 1'b0;
                if (ngr < 3) d_addr = d_addr + 10'd1;
                else         d_req = 1'b0;
            end
            if (mem_rden) rd_cnt++;
            if (d_gnt) begin ngr++; pend = 1'b1; end
            if (d_rvalid) begin
                chkw("b2b_cycle", 32'(c), 32'(2 + 3 * nrv));
                chkw("b2b_data", d_rdata, ref_mem[nrv + 1]);
                nrv++;
            end
        end
        chkw("b2b_rvalid_count", 32'(nrv), 32'd3);
        chkw("b2b_rden_count", 32'(rd_cnt), 32'd3);
        exp_d = ref_mem[3];

        for (int n = 0; n < 40; n++) begin
            pd = 1'($urandom_range(0, 1));
            we = pd ? 1'($urandom_range(0, 1)) : 1'b0;
            ra = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(256, 1023)) : 10'($urandom_range(0, 15));
            run_txn(pd, we, ra, $urandom);
            for (int g = $urandom_range(0, 2); g > 0; g--) tick;
        end

        // Reset while a read is in RESP.
        run_txn(1'b1, 1'b1, 10'd20, 32'h5A5A_1234);
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd20;
        tick;
        chk("rstrd_gnt", d_gnt, 1'b1);
        tick;
        d_req = 1'b0;
        chk("rstrd_rvalid_pre", d_rvalid, 1'b1);
        #1 Reset_n = 1'b0;
        #1;
        chk("rstrd_outputs_zero",
            |{i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err, i_err,
              mem_rden, mem_wren, mem_addr, mem_data}, 1'b0);
        tick; tick;
        Reset_n = 1'b1;
        exp_d = '0; exp_i = '0;
        for (int c = 0; c < 4; c++) begin
            tick;
            chk("rstrd_quiet", d_rvalid | d_gnt, 1'b0);
        end
        run_txn(1'b1, 1'b0, 10'd20, 32'h0);
        chkw("rstrd_next_read", d_rdata, 32'h5A5A_1234);

        // Contention from a fresh reset (priority pointer back at D).
        Reset_n = 1'b0; tick; Reset_n = 1'b1; tick;
        d_we = 1'b0; d_addr = 10'd7; i_addr = 10'd9;
        d_req = 1'b1; i_req = 1'b1;
        for (int c = 0; c < 60 && glog.size() < 8; c++) begin
            tick;
            chk("cont_one_gnt", i_gnt & d_gnt, 1'b0);
            if (d_gnt)      glog.push_back(1'b1);
            else if (i_gnt) glog.push_back(1'b0);
        end
        chkw("cont_grant_count", 32'(glog.size()), 32'd8);
        for (int k = 0; k < glog.size(); k++)
            chk($sformatf("cont_order_%0d", k), glog[k], RR ? (k % 2 == 0) : 1'b1);
        tick;
        d_req = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            tick;
            if (i_gnt) seen = 1'b1;
        end
        chk("cont_i_served", seen, 1'b1);
        tick;
        i_req = 1'b0;
        tick; tick; tick;
        chkw("cont_d_rdata", d_rdata, ref_mem[7]);
        chkw("cont_i_rdata", i_rdata, ref_mem[9]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
